// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter.
// Words are accepted over a valid/ready handshake into a small FIFO and are
// shifted out MSB-first as back-to-back W-bit frames. When the FIFO is empty,
// an all-zero idle frame is sent instead, so the frame grid never slips.
// The downstream detector counts frames from the same reset and relies on this.
module serial_frame_tx #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W-1:0]             data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic                     Dout,
  output logic                     frame_start,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               ones_frames
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [W-1:0]  r_shreg;
  logic [BW-1:0] r_bidx;
  logic [7:0]    r_ones;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_boundary;
  logic          w_pop;
  logic [W-1:0]  w_head;

  assign w_full     = (r_level == LW'(DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_push     = data_valid && !w_full;
  assign w_boundary = (r_bidx == BW'(W - 1));
  // The pop decision uses the occupancy before this edge. A word pushed on a
  // boundary edge into an empty FIFO therefore waits for the next boundary.
  assign w_pop      = w_boundary && !w_empty;
  assign w_head     = r_mem[r_rptr];

  // FIFO storage: written on every accepted push.
  // NOTE: the storage array has no reset. Its contents are only read when
  // r_level says they are valid, so clearing it would only cost flops.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_in;
    end
  end

  // FIFO bookkeeping: pointers wrap modulo DEPTH, level tracks push minus pop.
  // NOTE: every sequential block uses non-blocking assignments, so the whole
  // design samples the pre-edge values consistently regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Bit stepping: shift within a frame, and load the next word or an idle
  // frame on the boundary. Count real all-ones frames as they are loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
      r_bidx  <= '0;
      r_ones  <= '0;
    end else if (w_boundary) begin
      r_bidx <= '0;
      if (w_pop) begin
        r_shreg <= w_head;
        if ((&w_head) && (r_ones != 8'hFF)) begin
          r_ones <= r_ones + 8'd1;
        end
      end else begin
        r_shreg <= '0;
      end
    end else begin
      r_shreg <= {r_shreg[W-2:0], 1'b0};
      r_bidx  <= r_bidx + BW'(1);
    end
  end

  assign Dout        = r_shreg[W-1];
  assign frame_start = (r_bidx == '0);
  assign data_ready  = !w_full;
  assign level       = r_level;
  assign ones_frames = r_ones;

endmodule
